mips_ctrl_fsm: RTL and testbench
================================

# mips_ctrl_fsm

Multi-cycle control unit for the 31-instruction MIPS core; it is the producer of the 5-bit `aluc` code consumed by the datapath ALU. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memory. It drives every datapath strobe and mux select. It also raises a sticky trap on undecodable instructions.

## Interface
- `W_STATE`, 3: state register width; exported for debug.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ir` input 32: instruction register contents from the datapath; stable from DECODE until the next FETCH.
- `zero` input 1: ALU zero flag; 1 when the ALU result is 0.
- `im_ack` / `dm_ack` input 1 each: memory handshake acknowledges.
- `im_req` output 1: instruction fetch request.
- `ir_we` output 1: load the IR.
- `pc_we` output 1: write the PC.
- `pc_src` output 2: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
- `aluc` output 5: ALU operation code.
- `alu_a_sel` output 1: 0 = rs, 1 = zero-extended shamt.
- `alu_b_sel` output 2: 0 = rt, 1 = sign-extended imm16, 2 = zero-extended imm16.
- `rf_we` output 1: register file write enable.
- `rf_waddr_sel` output 2: 0 = rd, 1 = rt, 2 = $31.
- `rf_wdata_sel` output 2: 0 = ALU result, 1 = memory read data, 2 = PC (already holds PC+4).
- `dm_req` / `dm_we` output 1 each: data memory request and write.
- `illegal` output 1: sticky trap flag.
- `state` output `W_STATE`: current state.

## Operation
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5. Codes 6 and 7 return to FETCH.
- FETCH: `im_req` = 1. On a cycle with `im_ack` = 1, assert `ir_we` = 1 and `pc_we` = 1 with `pc_src` = 0, then go to DECODE. Otherwise hold.
- DECODE: register `aluc`, the operand selects, and the instruction class from `ir`.
  - Unlisted opcode/funct: go to TRAP.
  - J: `pc_we` with `pc_src` = 2, then go to FETCH.
  - JAL: as J, plus `rf_we` with `rf_waddr_sel` = 2 and `rf_wdata_sel` = 2, same cycle.
  - JR: `pc_we` with `pc_src` = 3, then go to FETCH.
  - Everything else: go to EXEC.
- EXEC: `aluc` and the selects are valid.
  - BEQ: `pc_we` = `zero`, `pc_src` = 1, then go to FETCH.
  - BNE: `pc_we` = ~`zero`, `pc_src` = 1, then go to FETCH.
  - LW/SW: go to MEM.
  - Others: go to WB.
- MEM: `dm_req` = 1, with `dm_we` = 1 for SW. Hold until `dm_ack`. SW then goes to FETCH; LW goes to WB.
- WB: `rf_we` = 1 for exactly one cycle, then go to FETCH.
  - `rf_wdata_sel` = 1 for LW, else 0.
  - `rf_waddr_sel` = 0 for R-type, 1 for I-type.
- TRAP: terminal state. `illegal` = 1; all strobes are 0 until reset.
- `aluc` encoding, R-type (op = 0, funct → code):
  - 20 ADD 00000, 21 ADDU 00001, 22 SUB 00010, 23 SUBU 00011
  - 24 AND 00100, 25 OR 00101, 26 XOR 00110, 27 NOR 00111
  - 2A SLT 01000, 2B SLTU 01001
  - 00 SLL 01010, 02 SRL 01011, 03 SRA 01100
  - 04 SLLV 01101, 06 SRLV 01110, 07 SRAV 01111
  - 08 JR 10000
- `aluc` encoding, I/J-type (op → code):
  - 08 ADDI 10001, 09 ADDIU 10010, 0C ANDI 10011, 0D ORI 10100, 0E XORI 10101
  - 23 LW 10110, 2B SW 10111
  - 04 BEQ 11000, 05 BNE 11001
  - 0A SLTI 11010, 0B SLTIU 11011, 0F LUI 11100
  - 02 J 11101, 03 JAL 11110
- Operand selects:
  - `alu_a_sel` = 1 only for SLL/SRL/SRA.
  - `alu_b_sel` = 2 for ANDI/ORI/XORI/LUI.
  - `alu_b_sel` = 1 for ADDI/ADDIU/LW/SW/SLTI/SLTIU.
  - `alu_b_sel` = 0 for R-type and BEQ/BNE.
- Strobes (`im_req`, `ir_we`, `pc_we`, `rf_we`, `dm_req`, `dm_we`) are Moore/Mealy-combinational from `state`, the registered decode, and the ack/`zero` inputs. No strobe is ever asserted outside its listed state.

## Timing
- While `rst` = 1:
  - `state` = FETCH (0).
  - `aluc` = 00000; all selects = 0.
  - `illegal` = 0.
  - All strobes forced to 0, including `im_req`.
- First rising edge after `rst` falls: FETCH with `im_req` = 1.
- An ack is sampled at the rising edge while its request is high. An ack arriving in the first request cycle gives zero wait states. An ack without a request is ignored.
- Zero-wait latencies:
  - J/JR/JAL: 2 cycles.
  - Branches: 3 cycles.
  - ALU ops and SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- `aluc` changes only on the DECODE→EXEC edge and holds through WB/MEM.
- Reset asserted mid-MEM or mid-FETCH: requests drop asynchronously; no write strobe completes.
- `pc_we` and `rf_we` in the same cycle occur only for JAL.

## Test plan
- Reset release, `ir` = 0x012A4020 (add $8,$9,$10), `im_ack` tied 1:
  - `state` sequence 0,1,2,4,0.
  - `aluc` = 00000 in EXEC.
  - `rf_we` = 1 in WB with `rf_waddr_sel` = 0 and `rf_wdata_sel` = 0.
- `ir` = 0x8D090004 (lw), `dm_ack` delayed 3 cycles:
  - MEM lasts 4 cycles with `dm_req` = 1 and `dm_we` = 0.
  - `aluc` = 10110, `alu_b_sel` = 1.
  - WB has `rf_wdata_sel` = 1 and `rf_waddr_sel` = 1.
- `ir` = 0x11090003 (beq):
  - `zero` = 1: `pc_we` = 1 in EXEC with `pc_src` = 1.
  - `zero` = 0: `pc_we` = 0.
  - Both cases return to FETCH after 3 cycles.
- `ir` = 0x0C000010 (jal):
  - In DECODE, `pc_we` = 1 with `pc_src` = 2.
  - Same cycle, `rf_we` = 1 with `rf_waddr_sel` = 2 and `rf_wdata_sel` = 2.
  - Next cycle is FETCH.
- `ir` = 0x00094080 (sll $8,$9,2):
  - `aluc` = 01010 and `alu_a_sel` = 1.
  - `ir` = 0x3528FFFF (ori) instead: `aluc` = 10100 and `alu_b_sel` = 2.
- `ir` = 0xFC000000:
  - TRAP is entered after DECODE, with `illegal` = 1 and no strobes.
  - Asserting `rst` mid-TRAP clears `illegal` immediately.

Source files
------------

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle control FSM for the 31-instruction MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and selects, traps on bad opcodes.
module mips_ctrl_fsm #(
    parameter int W_STATE = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ir,
    input  logic               zero,
    input  logic               im_ack,
    input  logic               dm_ack,
    output logic               im_req,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic [4:0]         aluc,
    output logic               alu_a_sel,
    output logic [1:0]         alu_b_sel,
    output logic               rf_we,
    output logic [1:0]         rf_waddr_sel,
    output logic [1:0]         rf_wdata_sel,
    output logic               dm_req,
    output logic               dm_we,
    output logic               illegal,
    output logic [W_STATE-1:0] state
);

    typedef enum logic [W_STATE-1:0] {
        S_FETCH  = 'd0,
        S_DECODE = 'd1,
        S_EXEC   = 'd2,
        S_MEM    = 'd3,
        S_WB     = 'd4,
        S_TRAP   = 'd5
    } state_t;

    typedef enum logic [3:0] {
        C_RR, C_RI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
    } cls_t;

    state_t     st;
    cls_t       cls;
    cls_t       d_cls;
    logic [4:0] d_aluc;
    logic       d_asel;
    logic [1:0] d_bsel;
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_ir;

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign unused_ir = ^ir[25:6];

    // Instruction decode; consumed directly in DECODE, latched on DECODE->EXEC.
    always_comb begin
        d_aluc = 5'b00000;
        d_asel = 1'b0;
        d_bsel = 2'd0;
        d_cls  = C_ILL;
        case (op)
            6'h00: begin
                d_cls = C_RR;
                case (funct)
                    6'h20: d_aluc = 5'b00000;
                    6'h21: d_aluc = 5'b00001;
                    6'h22: d_aluc = 5'b00010;
                    6'h23: d_aluc = 5'b00011;
                    6'h24: d_aluc = 5'b00100;
                    6'h25: d_aluc = 5'b00101;
                    6'h26: d_aluc = 5'b00110;
                    6'h27: d_aluc = 5'b00111;
                    6'h2A: d_aluc = 5'b01000;
                    6'h2B: d_aluc = 5'b01001;
                    6'h00: begin d_aluc = 5'b01010; d_asel = 1'b1; end
                    6'h02: begin d_aluc = 5'b01011; d_asel = 1'b1; end
                    6'h03: begin d_aluc = 5'b01100; d_asel = 1'b1; end
                    6'h04: d_aluc = 5'b01101;
                    6'h06: d_aluc = 5'b01110;
                    6'h07: d_aluc = 5'b01111;
                    6'h08: begin d_aluc = 5'b10000; d_cls = C_JR; end
                    default: d_cls = C_ILL;
                endcase
            end
            6'h08: begin d_aluc = 5'b10001; d_bsel = 2'd1; d_cls = C_RI;  end
            6'h09: begin d_aluc = 5'b10010; d_bsel = 2'd1; d_cls = C_RI;  end
            6'h0C: begin d_aluc = 5'b10011; d_bsel = 2'd2; d_cls = C_RI;  end
            6'h0D: begin d_aluc = 5'b10100; d_bsel = 2'd2; d_cls = C_RI;  end
            6'h0E: begin d_aluc = 5'b10101; d_bsel = 2'd2; d_cls = C_RI;  end
            6'h23: begin d_aluc = 5'b10110; d_bsel = 2'd1; d_cls = C_LW;  end
            6'h2B: begin d_aluc = 5'b10111; d_bsel = 2'd1; d_cls = C_SW;  end
            6'h04: begin d_aluc = 5'b11000; d_cls = C_BEQ; end
            6'h05: begin d_aluc = 5'b11001; d_cls = C_BNE; end
            6'h0A: begin d_aluc = 5'b11010; d_bsel = 2'd1; d_cls = C_RI;  end
            6'h0B: begin d_aluc = 5'b11011; d_bsel = 2'd1; d_cls = C_RI;  end
            6'h0F: begin d_aluc = 5'b11100; d_bsel = 2'd2; d_cls = C_RI;  end
            6'h02: begin d_aluc = 5'b11101; d_cls = C_J;   end
            6'h03: begin d_aluc = 5'b11110; d_cls = C_JAL; end
            default: d_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_FETCH;
            cls       <= C_RR;
            aluc      <= 5'b00000;
            alu_a_sel <= 1'b0;
            alu_b_sel <= 2'd0;
        end else begin
            case (st)
                S_FETCH:  if (im_ack) st <= S_DECODE;
                S_DECODE: begin
                    case (d_cls)
                        C_ILL:             st <= S_TRAP;
                        C_J, C_JAL, C_JR:  st <= S_FETCH;
                        default: begin
                            st        <= S_EXEC;
                            cls       <= d_cls;
                            aluc      <= d_aluc;
                            alu_a_sel <= d_asel;
                            alu_b_sel <= d_bsel;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (cls)
                        C_BEQ, C_BNE: st <= S_FETCH;
                        C_LW, C_SW:   st <= S_MEM;
                        default:      st <= S_WB;
                    endcase
                end
                S_MEM:   if (dm_ack) st <= (cls == C_SW) ? S_FETCH : S_WB;
                S_WB:    st <= S_FETCH;
                S_TRAP:  st <= S_TRAP;
                default: st <= S_FETCH;
            endcase
        end
    end

    // Strobes are gated by rst so requests drop the instant reset asserts.
    always_comb begin
        im_req       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        rf_we        = 1'b0;
        rf_waddr_sel = 2'd0;
        rf_wdata_sel = 2'd0;
        dm_req       = 1'b0;
        dm_we        = 1'b0;
        if (!rst) begin
            case (st)
                S_FETCH: begin
                    im_req = 1'b1;
                    ir_we  = im_ack;
                    pc_we  = im_ack;
                end
                S_DECODE: begin
                    case (d_cls)
                        C_J:  begin pc_we = 1'b1; pc_src = 2'd2; end
                        C_JR: begin pc_we = 1'b1; pc_src = 2'd3; end
                        C_JAL: begin
                            pc_we        = 1'b1;
                            pc_src       = 2'd2;
                            rf_we        = 1'b1;
                            rf_waddr_sel = 2'd2;
                            rf_wdata_sel = 2'd2;
                        end
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    if (cls == C_BEQ) begin pc_we = zero;  pc_src = 2'd1; end
                    if (cls == C_BNE) begin pc_we = ~zero; pc_src = 2'd1; end
                end
                S_MEM: begin
                    dm_req = 1'b1;
                    dm_we  = (cls == C_SW);
                end
                S_WB: begin
                    rf_we        = 1'b1;
                    rf_waddr_sel = (cls == C_RR) ? 2'd0 : 2'd1;
                    rf_wdata_sel = (cls == C_LW) ? 2'd1 : 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign illegal = (st == S_TRAP);
    assign state   = st;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm: walks each instruction class and checks states and strobes.
module tb_mips_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        zero = 1'b0;
    logic        im_ack = 1'b0;
    logic        dm_ack = 1'b0;
    logic        im_req, ir_we, pc_we, alu_a_sel, rf_we, dm_req, dm_we, illegal;
    logic [1:0]  pc_src, alu_b_sel, rf_waddr_sel, rf_wdata_sel;
    logic [4:0]  aluc;
    logic [2:0]  state;

    int n_chk = 0;
    int n_err = 0;

    mips_ctrl_fsm #(.W_STATE(3)) dut (
        .clk(clk), .rst(rst), .ir(ir), .zero(zero), .im_ack(im_ack), .dm_ack(dm_ack),
        .im_req(im_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .aluc(aluc),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
        .rf_waddr_sel(rf_waddr_sel), .rf_wdata_sel(rf_wdata_sel),
        .dm_req(dm_req), .dm_we(dm_we), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // From FETCH: load a new instruction and step into DECODE.
    task automatic fetch(input logic [31:0] instr);
        chk("fetch_state", 32'(state), 0);
        ir     = instr;
        im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        chk("decode_state", 32'(state), 1);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_im_req", 32'(im_req), 0);
        chk("rst_aluc", 32'(aluc), 0);
        chk("rst_illegal", 32'(illegal), 0);
        ir     = 32'h012A4020;
        im_ack = 1'b1;
        rst    = 1'b0;
        #1;
        chk("add_im_req", 32'(im_req), 1);
        chk("add_ir_we", 32'(ir_we), 1);
        chk("add_pc_we", 32'(pc_we), 1);
        tick();
        im_ack = 1'b0;
        chk("add_s1", 32'(state), 1);
        tick();
        chk("add_s2", 32'(state), 2);
        chk("add_aluc", 32'(aluc), 32'b00000);
        chk("add_exec_rf_we", 32'(rf_we), 0);
        tick();
        chk("add_s4", 32'(state), 4);
        chk("add_rf_we", 32'(rf_we), 1);
        chk("add_waddr", 32'(rf_waddr_sel), 0);
        chk("add_wdata", 32'(rf_wdata_sel), 0);
        tick();
        chk("add_s0", 32'(state), 0);

        // FETCH holds without ack
        tick();
        chk("hold_state", 32'(state), 0);
        chk("hold_im_req", 32'(im_req), 1);
        chk("hold_ir_we", 32'(ir_we), 0);

        // lw with dm_ack delayed 3 cycles
        fetch(32'h8D090004);
        tick();
        chk("lw_exec", 32'(state), 2);
        chk("lw_aluc", 32'(aluc), 32'b10110);
        chk("lw_bsel", 32'(alu_b_sel), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dm_ack = 1'b1;
            chk("lw_mem_state", 32'(state), 3);
            chk("lw_dm_req", 32'(dm_req), 1);
            chk("lw_dm_we", 32'(dm_we), 0);
            tick();
        end
        dm_ack = 1'b0;
        chk("lw_wb", 32'(state), 4);
        chk("lw_rf_we", 32'(rf_we), 1);
        chk("lw_wdata", 32'(rf_wdata_sel), 1);
        chk("lw_waddr", 32'(rf_waddr_sel), 1);
        chk("lw_aluc_hold", 32'(aluc), 32'b10110);
        tick();
        chk("lw_done", 32'(state), 0);

        // sw, zero-wait memory
        fetch(32'hAD090004);
        tick();
        chk("sw_aluc", 32'(aluc), 32'b10111);
        tick();
        dm_ack = 1'b1;
        chk("sw_mem", 32'(state), 3);
        chk("sw_dm_we", 32'(dm_we), 1);
        chk("sw_rf_we", 32'(rf_we), 0);
        tick();
        dm_ack = 1'b0;
        chk("sw_done", 32'(state), 0);

        // beq taken / not taken
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            fetch(32'h11090003);
            tick();
            chk("beq_exec", 32'(state), 2);
            chk("beq_aluc", 32'(aluc), 32'b11000);
            chk("beq_pc_we", 32'(pc_we), 32'(z));
            chk("beq_pc_src", 32'(pc_src), 1);
            tick();
            chk("beq_done", 32'(state), 0);
        end
        // bne taken when zero = 0
        fetch(32'h15090003);
        tick();
        chk("bne_pc_we", 32'(pc_we), 1);
        tick();

        // jal
        fetch(32'h0C000010);
        chk("jal_pc_we", 32'(pc_we), 1);
        chk("jal_pc_src", 32'(pc_src), 2);
        chk("jal_rf_we", 32'(rf_we), 1);
        chk("jal_waddr", 32'(rf_waddr_sel), 2);
        chk("jal_wdata", 32'(rf_wdata_sel), 2);
        chk("jal_aluc_hold", 32'(aluc), 32'b11001);
        tick();
        chk("jal_done", 32'(state), 0);

        // jr $9
        fetch(32'h01200008);
        chk("jr_pc_src", 32'(pc_src), 3);
        chk("jr_rf_we", 32'(rf_we), 0);
        tick();
        chk("jr_done", 32'(state), 0);

        // sll, then ori
        fetch(32'h00094080);
        tick();
        chk("sll_aluc", 32'(aluc), 32'b01010);
        chk("sll_asel", 32'(alu_a_sel), 1);
        tick();
        tick();
        fetch(32'h3528FFFF);
        tick();
        chk("ori_aluc", 32'(aluc), 32'b10100);
        chk("ori_bsel", 32'(alu_b_sel), 2);
        chk("ori_asel", 32'(alu_a_sel), 0);
        tick();
        chk("ori_waddr", 32'(rf_waddr_sel), 1);
        tick();

        // illegal opcode traps
        fetch(32'hFC000000);
        tick();
        chk("trap_state", 32'(state), 5);
        chk("trap_illegal", 32'(illegal), 1);
        chk("trap_im_req", 32'(im_req), 0);
        chk("trap_pc_we", 32'(pc_we), 0);
        im_ack = 1'b1;
        tick();
        chk("trap_stay", 32'(state), 5);
        chk("trap_no_ir_we", 32'(ir_we), 0);
        #2 rst = 1'b1;
        #1;
        chk("trap_rst_illegal", 32'(illegal), 0);
        chk("trap_rst_state", 32'(state), 0);
        chk("trap_rst_im_req", 32'(im_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
